// File: rtl/vga_pkg.sv
// Shared VGA timing and framebuffer constants plus the 9-bit RGB 3:3:3 cell layout.
package vga_pkg;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int CELLS_X    = 80;
  localparam int CELLS_Y    = 60;
  localparam int CELL_SHIFT = 3;
  localparam int FB_DEPTH   = CELLS_X * CELLS_Y;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb_t;
endpackage

// File: rtl/vga_cell_addr.sv
// Registered pixel -> row-major cell address for an 80-cell-wide framebuffer.
module vga_cell_addr #(
  parameter int ADDR_W     = 13,
  parameter int CELL_SHIFT = vga_pkg::CELL_SHIFT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [9:0]        px,
  input  logic [9:0]        py,
  output logic [ADDR_W-1:0] addr_q
);
  logic [ADDR_W-1:0] row, col, addr_d;

  always_comb begin
    row    = ADDR_W'(py >> CELL_SHIFT);
    col    = ADDR_W'(px >> CELL_SHIFT);
    addr_d = addr_q;
    // row*80 as row*64 + row*16 keeps the multiplier out of the fetch path
    if (en) addr_d = (row << 6) + (row << 4) + col;
  end

  always_ff @(posedge clk) begin
    if (reset) addr_q <= '0;
    else       addr_q <= addr_d;
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: fixed scanout fetch slots, host writes in the gaps.
module vga_fb_arbiter #(
  parameter int CELLS_X        = vga_pkg::CELLS_X,
  parameter int CELLS_Y        = vga_pkg::CELLS_Y,
  parameter int CELL_SHIFT     = vga_pkg::CELL_SHIFT,
  parameter int ADDR_W         = 13,
  parameter bit WR_VBLANK_ONLY = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [9:0]        i_px,
  input  logic [9:0]        i_py,
  input  logic              i_activeArea,
  input  logic              i_wrReq,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [8:0]        i_wrData,
  output logic              o_wrAck,
  output logic              o_wrDropped,
  output logic [ADDR_W-1:0] o_ramAddr,
  output logic              o_ramWe,
  output logic [8:0]        o_ramWData,
  input  logic [8:0]        i_ramRData,
  output logic [2:0]        o_red,
  output logic [2:0]        o_green,
  output logic [2:0]        o_blue
);
  localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(CELLS_X * CELLS_Y);

  logic              fetch_slot, wr_open, grant, in_range;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic              src_wr_q, src_wr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [8:0]        wdata_q, wdata_d;
  logic              we_q, we_d, ack_q, ack_d, drop_q, drop_d;
  logic [1:0]        fetch_pipe_q, fetch_pipe_d, act_pipe_q, act_pipe_d;
  vga_pkg::rgb_t     cell_q, cell_d, rgb_q, rgb_d;

  assign fetch_slot = i_activeArea && (i_px[CELL_SHIFT-1:0] == '0)
                      && (i_px < 10'(vga_pkg::H_ACTIVE));
  assign wr_open    = !WR_VBLANK_ONLY || (i_py >= 10'(vga_pkg::V_ACTIVE));
  // ack_q guard spaces grants so the writer can retire its request before re-evaluation
  assign grant      = !fetch_slot && i_wrReq && !ack_q && wr_open;
  assign in_range   = i_wrAddr < FB_LIMIT;

  vga_cell_addr #(.ADDR_W(ADDR_W), .CELL_SHIFT(CELL_SHIFT)) u_cell_addr (
    .clk    (i_clk),
    .reset  (i_reset),
    .en     (fetch_slot),
    .px     (i_px),
    .py     (i_py),
    .addr_q (fetch_addr_q)
  );

  always_comb begin
    src_wr_d  = src_wr_q;
    wr_addr_d = wr_addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    ack_d     = 1'b0;
    drop_d    = 1'b0;
    if (fetch_slot) begin
      src_wr_d = 1'b0;
    end else if (grant) begin
      src_wr_d  = 1'b1;
      wr_addr_d = i_wrAddr;
      wdata_d   = i_wrData;
      ack_d     = 1'b1;
      we_d      = in_range;
      drop_d    = !in_range;
    end
    fetch_pipe_d = {fetch_pipe_q[0], fetch_slot};
    act_pipe_d   = {act_pipe_q[0], i_activeArea};
    cell_d       = fetch_pipe_q[1] ? vga_pkg::rgb_t'(i_ramRData) : cell_q;
    // fresh RAM data bypasses the latch so colour lands 3 cycles after the pixel
    rgb_d        = '0;
    if (act_pipe_q[1]) rgb_d = cell_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      src_wr_q     <= 1'b0;
      wr_addr_q    <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      ack_q        <= 1'b0;
      drop_q       <= 1'b0;
      fetch_pipe_q <= '0;
      act_pipe_q   <= '0;
      cell_q       <= '0;
      rgb_q        <= '0;
    end else begin
      src_wr_q     <= src_wr_d;
      wr_addr_q    <= wr_addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      ack_q        <= ack_d;
      drop_q       <= drop_d;
      fetch_pipe_q <= fetch_pipe_d;
      act_pipe_q   <= act_pipe_d;
      cell_q       <= cell_d;
      rgb_q        <= rgb_d;
    end
  end

  assign o_ramAddr   = src_wr_q ? wr_addr_q : fetch_addr_q;
  assign o_ramWe     = we_q;
  assign o_ramWData  = wdata_q;
  assign o_wrAck     = ack_q;
  assign o_wrDropped = drop_q;
  assign o_red       = rgb_q.r;
  assign o_green     = rgb_q.g;
  assign o_blue      = rgb_q.b;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench: scanout fetch timing, write arbitration, vblank-only writes, reset.
module tb_vga_fb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  px, py;
  logic        act;
  logic        req;
  logic [12:0] waddr;
  logic [8:0]  wdata;

  logic        ack1, drop1, we1;
  logic [12:0] raddr1;
  logic [8:0]  wd1, rdata1;
  logic [2:0]  r1, g1, b1;
  logic        ack2, drop2, we2;
  logic [12:0] raddr2;
  logic [8:0]  wd2;
  logic [8:0]  rdata2 = 9'h0;
  logic [2:0]  r2, g2, b2;

  logic [8:0]  mem [0:8191];
  logic [8:0]  obs [0:31];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #20 clk = ~clk;

  vga_fb_arbiter u_dut (
    .i_clk(clk), .i_reset(rst), .i_px(px), .i_py(py), .i_activeArea(act),
    .i_wrReq(req), .i_wrAddr(waddr), .i_wrData(wdata),
    .o_wrAck(ack1), .o_wrDropped(drop1), .o_ramAddr(raddr1), .o_ramWe(we1),
    .o_ramWData(wd1), .i_ramRData(rdata1), .o_red(r1), .o_green(g1), .o_blue(b1)
  );

  vga_fb_arbiter #(.WR_VBLANK_ONLY(1'b1)) u_dut_vb (
    .i_clk(clk), .i_reset(rst), .i_px(px), .i_py(py), .i_activeArea(act),
    .i_wrReq(req), .i_wrAddr(waddr), .i_wrData(wdata),
    .o_wrAck(ack2), .o_wrDropped(drop2), .o_ramAddr(raddr2), .o_ramWe(we2),
    .o_ramWData(wd2), .i_ramRData(rdata2), .o_red(r2), .o_green(g2), .o_blue(b2)
  );

  // read-first synchronous single-port RAM
  always @(posedge clk) begin
    rdata1 <= mem[raddr1];
    if (we1) mem[raddr1] = wd1;
  end

  task automatic drive(input int x, input int y);
    px  = 10'(x);
    py  = 10'(y);
    act = (x < 640) && (y < 480);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; waddr = '0; wdata = '0;
    drive(0, 0);
    tick(); tick();
    n_checks++;
    if ({ack1, drop1, we1, raddr1, wd1, r1, g1, b1} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got ack=%b drop=%b we=%b addr=%0d wd=%h rgb=%h want all 0",
               ack1, drop1, we1, raddr1, wd1, {r1, g1, b1});
    end
    n_checks++;
    if (ack2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ack_vb got=%b want=0", ack2);
    end
    rst = 1'b0;
  endtask

  task automatic test_scanout();
    for (int i = 0; i < 28; i++) begin
      if (i < 24) drive(i, 0);
      else        drive(640 + i - 24, 0);
      tick();
      obs[i] = {r1, g1, b1};
    end
    for (int j = 0; j < 8; j++) begin
      n_checks++;
      if (obs[j+2] !== 9'd0) begin
        n_fail++;
        $display("FAIL scan_cell0 px=%0d got=%h want=000", j, obs[j+2]);
      end
    end
    for (int j = 8; j < 16; j++) begin
      n_checks++;
      if (obs[j+2] !== 9'd1) begin
        n_fail++;
        $display("FAIL scan_cell1_hold px=%0d got=%h want=001", j, obs[j+2]);
      end
    end
    n_checks++;
    if (obs[18] !== 9'd2) begin
      n_fail++;
      $display("FAIL scan_cell2 got=%h want=002", obs[18]);
    end
    for (int j = 24; j < 26; j++) begin
      n_checks++;
      if (obs[j+2] !== 9'd0) begin
        n_fail++;
        $display("FAIL scan_blank px=%0d got=%h want=000", 640 + j - 24, obs[j+2]);
      end
    end
  endtask

  task automatic test_fetch_addr();
    drive(0, 8); tick();
    n_checks++;
    if (raddr1 !== 13'd80) begin
      n_fail++;
      $display("FAIL fetch_addr_0_8 got=%0d want=80", raddr1);
    end
    drive(1, 8); tick(); drive(2, 8); tick();
    n_checks++;
    if ({r1, g1, b1} !== 9'd80) begin
      n_fail++;
      $display("FAIL colour_cell80 got=%h want=%h", {r1, g1, b1}, 9'd80);
    end
    drive(632, 479); tick();
    n_checks++;
    if (raddr1 !== 13'd4799) begin
      n_fail++;
      $display("FAIL fetch_addr_632_479 got=%0d want=4799", raddr1);
    end
    drive(633, 479); tick(); drive(634, 479); tick();
    n_checks++;
    if ({r1, g1, b1} !== 9'd191) begin
      n_fail++;
      $display("FAIL colour_cell4799 got=%h want=%h", {r1, g1, b1}, 9'd191);
    end
    for (int k = 0; k < 10; k++) begin
      drive(640 + k, 479); tick();
      n_checks++;
      if (raddr1 !== 13'd4799 || we1 !== 1'b0) begin
        n_fail++;
        $display("FAIL hblank_no_read px=%0d got addr=%0d we=%b want 4799/0", 640 + k, raddr1, we1);
      end
    end
  endtask

  task automatic test_write_defer();
    req = 1'b0;
    drive(14, 16); tick();
    drive(15, 16); tick();
    drive(16, 16); req = 1'b1; waddr = 13'd5; wdata = 9'h1FF; tick();
    n_checks++;
    if (ack1 !== 1'b0 || raddr1 !== 13'd162) begin
      n_fail++;
      $display("FAIL defer_fetch_slot got ack=%b addr=%0d want 0/162", ack1, raddr1);
    end
    drive(17, 16); tick();
    n_checks++;
    if ({ack1, we1, drop1} !== 3'b110 || raddr1 !== 13'd5 || wd1 !== 9'h1FF) begin
      n_fail++;
      $display("FAIL deferred_ack got ack=%b we=%b drop=%b addr=%0d wd=%h want 1/1/0/5/1ff",
               ack1, we1, drop1, raddr1, wd1);
    end
    req = 1'b0;
    drive(18, 16); tick();
    n_checks++;
    if (ack1 !== 1'b0 || we1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_single_pulse got ack=%b we=%b want 0/0", ack1, we1);
    end
    drive(40, 0); tick(); drive(41, 0); tick(); drive(42, 0); tick();
    n_checks++;
    if ({r1, g1, b1} !== 9'h1FF) begin
      n_fail++;
      $display("FAIL written_cell5_colour got=%h want=1ff", {r1, g1, b1});
    end
  endtask

  task automatic test_hblank_rate();
    req = 1'b0;
    drive(650, 20); tick();
    req = 1'b1; waddr = 13'd100; wdata = 9'd100;
    for (int k = 0; k < 8; k++) begin
      drive(651 + k, 20); tick();
      n_checks++;
      if (ack1 !== ((k % 2) == 0) || we1 !== ((k % 2) == 0)) begin
        n_fail++;
        $display("FAIL hblank_rate k=%0d got ack=%b we=%b want %0d", k, ack1, we1, (k % 2) == 0);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_active_rate();
    req = 1'b0;
    drive(7, 24); tick();
    req = 1'b1; waddr = 13'd200; wdata = 9'd200;
    for (int x = 8; x < 24; x++) begin
      drive(x, 24); tick();
      n_checks++;
      if (ack1 !== ((x % 2) == 1)) begin
        n_fail++;
        $display("FAIL active_rate px=%0d got ack=%b want %0d", x, ack1, (x % 2) == 1);
      end
      if ((x % 8) == 0) begin
        n_checks++;
        if (we1 !== 1'b0 || raddr1 !== 13'(240 + x / 8)) begin
          n_fail++;
          $display("FAIL active_fetch px=%0d got we=%b addr=%0d want 0/%0d", x, we1, raddr1, 240 + x / 8);
        end
      end else if ((x % 2) == 1) begin
        n_checks++;
        if (we1 !== 1'b1 || raddr1 !== 13'd200) begin
          n_fail++;
          $display("FAIL active_write px=%0d got we=%b addr=%0d want 1/200", x, we1, raddr1);
        end
      end
    end
    req = 1'b0;
  endtask

  task automatic test_vblank_only();
    req = 1'b0;
    drive(99, 100); tick();
    req = 1'b1; waddr = 13'd300; wdata = 9'(300);
    for (int x = 100; x < 110; x++) begin
      drive(x, 100); tick();
      n_checks++;
      if (ack2 !== 1'b0) begin
        n_fail++;
        $display("FAIL vb_only_active px=%0d got ack=%b want 0", x, ack2);
      end
    end
    drive(0, 480); tick();
    n_checks++;
    if (ack2 !== 1'b1 || we2 !== 1'b1 || raddr2 !== 13'd300) begin
      n_fail++;
      $display("FAIL vb_only_grant got ack=%b we=%b addr=%0d want 1/1/300", ack2, we2, raddr2);
    end
    req = 1'b0;
    drive(1, 480); tick();
    drive(799, 524); tick();
    req = 1'b1;
    for (int x = 0; x < 6; x++) begin
      drive(x, 0); tick();
      n_checks++;
      if (ack2 !== 1'b0) begin
        n_fail++;
        $display("FAIL vb_only_wrap px=%0d got ack=%b want 0", x, ack2);
      end
    end
    req = 1'b0;
    drive(10, 490); tick();
    req = 1'b1; waddr = 13'd4800; wdata = 9'h1FF;
    drive(11, 490); tick();
    n_checks++;
    if ({ack1, drop1, we1} !== 3'b110 || {ack2, drop2, we2} !== 3'b110) begin
      n_fail++;
      $display("FAIL dropped_4800 got ack/drop/we=%b%b%b vb=%b%b%b want 110/110",
               ack1, drop1, we1, ack2, drop2, we2);
    end
    req = 1'b0;
    drive(12, 490); tick();
    n_checks++;
    if (drop1 !== 1'b0 || ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_single_pulse got drop=%b ack=%b want 0/0", drop1, ack1);
    end
    req = 1'b1; waddr = 13'd4799; wdata = 9'd191;
    drive(13, 490); tick();
    n_checks++;
    if ({ack1, drop1, we1} !== 3'b101) begin
      n_fail++;
      $display("FAIL inrange_4799 got ack/drop/we=%b%b%b want 101", ack1, drop1, we1);
    end
    req = 1'b0;
    drive(14, 490); tick();
  endtask

  task automatic test_reset_mid();
    req = 1'b0;
    for (int x = 16; x < 21; x++) begin
      drive(x, 8); tick();
    end
    rst = 1'b1; req = 1'b1; waddr = 13'd10; wdata = 9'd10;
    drive(21, 8); tick();
    n_checks++;
    if ({ack1, drop1, we1, raddr1, wd1, r1, g1, b1} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got ack=%b drop=%b we=%b addr=%0d wd=%h rgb=%h want all 0",
               ack1, drop1, we1, raddr1, wd1, {r1, g1, b1});
    end
    drive(22, 8); tick();
    n_checks++;
    if (ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_ack got=%b want 0", ack1);
    end
    rst = 1'b0;
    drive(23, 8); tick();
    n_checks++;
    if (ack1 !== 1'b1 || raddr1 !== 13'd10 || {r1, g1, b1} !== 9'd0) begin
      n_fail++;
      $display("FAIL post_reset_ack got ack=%b addr=%0d rgb=%h want 1/10/000", ack1, raddr1, {r1, g1, b1});
    end
    req = 1'b0;
    for (int x = 24; x < 26; x++) begin
      drive(x, 8); tick();
      n_checks++;
      if ({r1, g1, b1} !== 9'd0) begin
        n_fail++;
        $display("FAIL post_reset_blank px=%0d got=%h want=000", x, {r1, g1, b1});
      end
    end
    for (int x = 26; x < 28; x++) begin
      drive(x, 8); tick();
      n_checks++;
      if ({r1, g1, b1} !== 9'd83) begin
        n_fail++;
        $display("FAIL post_reset_colour px=%0d got=%h want=%h", x, {r1, g1, b1}, 9'd83);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 9'(i);
    test_reset();
    test_scanout();
    test_fetch_addr();
    test_write_defer();
    test_hblank_rate();
    test_active_rate();
    test_vblank_only();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
